lcd_bus_fifo: RTL and testbench

Parametrised parallel-LCD write controller (ILI9341-class) on the picosoc iomem bus. CPU writes are queued in a FIFO; an independent strobe engine drains the queue onto the LCD bus with programmable setup/hold timing, so the CPU is not held for every byte. Supports an 8- or 16-bit LCD data bus, with DC captured per FIFO entry. Sits between the iomem decoder and the LCD pins.

---
 rtl/lcd_bus_fifo.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_lcd_bus_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_fifo.sv
// lcd_bus_fifo: queued parallel-LCD (ILI9341-class) write controller on the
// picosoc iomem bus. CPU writes land in a FIFO and a strobe engine drains
// them onto the LCD pins with programmable setup/hold timing.
// Optional solid-colour fill engine: compile with `define LCD_FILL_EN.
module lcd_bus_fifo #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int WR_LOW_CYC  = 1,
    parameter int WR_HIGH_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic              nreset,
    output logic              cmd_data,
    output logic              write_edge,
    output logic [DATA_W-1:0] dout
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LW      = AW + 1;
    localparam int CNT_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [7:0] A_DATA       = 8'h00;
    localparam logic [7:0] A_STATUS     = 8'h04;
    localparam logic [7:0] A_DC         = 8'h08;
    localparam logic [7:0] A_NRESET     = 8'h0C;
    localparam logic [7:0] A_FILL_COLOR = 8'h10;
    localparam logic [7:0] A_FILL_COUNT = 8'h14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HOLD
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clocks after the pin drops
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst;

    // Reset synchroniser: async set, shifted-out release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic              ready_q;
    logic [31:0]       rdata_q;
    logic              dc_reg_q;
    logic              nreset_q;

    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   pop_word;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic              we_q;
    logic              we_d;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;
    logic              cd_q;
    logic              cd_d;
    logic              start;
    logic              setup_done;
    logic              hold_done;

    logic              fill_hold;
    logic              fill_go;
    logic [DATA_W-1:0] fill_word;
    logic              fill_busy;

    logic [7:0]        reg_addr;
    logic              is_wr;
    logic              bus_req;
    logic              sel_data;
    logic              sel_dc;
    logic              sel_nreset;
    logic              stall;
    logic              done;
    logic [31:0]       status;
    logic              unused_bits;

    assign unused_bits = ^{iomem_addr[31:8], iomem_wdata};

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign reg_addr   = iomem_addr[7:0];
    assign is_wr      = |iomem_wstrb;
    assign bus_req    = iomem_valid && !ready_q;
    assign sel_data   = bus_req && is_wr && (reg_addr == A_DATA);
    assign sel_dc     = bus_req && is_wr && (reg_addr == A_DC);
    assign sel_nreset = bus_req && is_wr && (reg_addr == A_NRESET);

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
    assign pop_word   = mem_q[rd_ptr_q];

`ifdef LCD_FILL_EN
    logic              sel_fill_color;
    logic              sel_fill_count;
    logic [15:0]       fill_color_q;
    logic [16:0]       fill_count_q;
    logic              fill_busy_q;
    logic              fill_byte_q;
    logic [LW-1:0]     fill_ahead_q;
    logic              fill_last;

    assign sel_fill_color = bus_req && is_wr && (reg_addr == A_FILL_COLOR);
    assign sel_fill_count = bus_req && is_wr && (reg_addr == A_FILL_COUNT);

    // Entries queued before the FILL_COUNT write still drain first; once
    // they are gone the engine stops popping and emits fill pixels instead.
    assign fill_hold = fill_busy_q && (fill_ahead_q == '0);
    assign fill_go   = (state_q == S_IDLE) && fill_hold;
    assign fill_last = (DATA_W == 16) || fill_byte_q;
    assign fill_word = DATA_W'(fill_last ? fill_color_q : (fill_color_q >> 8));
    assign fill_busy = fill_busy_q;

    // Fill bookkeeping: colour, remaining pixels, byte phase, entries ahead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_color_q <= '0;
            fill_count_q <= '0;
            fill_busy_q  <= 1'b0;
            fill_byte_q  <= 1'b0;
            fill_ahead_q <= '0;
        end else begin
            if (sel_fill_color && done) begin
                fill_color_q <= iomem_wdata[15:0];
            end
            if (sel_fill_count && done && (iomem_wdata[16:0] != '0)) begin
                fill_count_q <= iomem_wdata[16:0];
                fill_busy_q  <= 1'b1;
                fill_byte_q  <= 1'b0;
                fill_ahead_q <= level_q - LW'(pop);
            end else if (fill_busy_q) begin
                if (pop && (fill_ahead_q != '0)) begin
                    fill_ahead_q <= fill_ahead_q - 1'b1;
                end
                if (fill_go) begin
                    if (fill_last) begin
                        fill_byte_q  <= 1'b0;
                        fill_count_q <= fill_count_q - 1'b1;
                        if (fill_count_q == 17'd1) begin
                            fill_busy_q <= 1'b0;
                        end
                    end else begin
                        fill_byte_q <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign fill_hold = 1'b0;
    assign fill_go   = 1'b0;
    assign fill_word = '0;
    assign fill_busy = 1'b0;
`endif

    // Decide whether the pending bus request can complete this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        stall = 1'b0;
        if (sel_data && fifo_full && !pop) begin
            stall = 1'b1;
        end
`ifdef LCD_FILL_EN
        if (sel_fill_count && fill_busy_q) begin
            stall = 1'b1;
        end
`endif
    end

    assign done = bus_req && !stall;
    assign push = sel_data && !stall;

    // STATUS word as seen at the cycle the read is accepted.
    always_comb begin
        status       = '0;
        status[0]    = !fifo_empty || (state_q != S_IDLE) || fill_busy;
        status[1]    = fifo_full;
        status[2]    = fill_busy;
        status[15:8] = 8'(level_q);
    end

    // Bus-side registers: ready pulse, read data, DC and NRESET controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            dc_reg_q <= 1'b0;
            nreset_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ready_q <= done;
            rdata_q <= (done && !is_wr && (reg_addr == A_STATUS)) ? status : 32'h0;
            if (sel_dc) begin
                dc_reg_q <= iomem_wdata[0];
            end
            if (sel_nreset) begin
                nreset_q <= iomem_wdata[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Pointers and level; a same-cycle push and pop leaves the level alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage write; each entry carries the DC value current at push time.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the level counter and
        // pointers define which entries are valid.
        if (push) begin
            mem_q[wr_ptr_q] <= {dc_reg_q, iomem_wdata[DATA_W-1:0]};
        end
    end

    // ------------------------------------------------------------------
    // Strobe engine
    // ------------------------------------------------------------------
    assign pop        = (state_q == S_IDLE) && !fifo_empty && !fill_hold;
    assign start      = pop || fill_go;
    assign setup_done = (cnt_q == CW'(WR_LOW_CYC - 1));
    assign hold_done  = (cnt_q == CW'(WR_HIGH_CYC - 1));

    // Engine state register and registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            dout_q  <= '0;
            cd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            dout_q  <= dout_d;
            cd_q    <= cd_d;
        end
    end

    // Next-state: IDLE -> SETUP (WR_LOW_CYC) -> HOLD (WR_HIGH_CYC) -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_SETUP;
            S_SETUP: if (setup_done) state_d = S_HOLD;
            S_HOLD:  if (hold_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: phase counter, write_edge, and the bus word latched on start.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        we_d   = we_q;
        dout_d = dout_q;
        cd_d   = cd_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    we_d   = 1'b0;
                    dout_d = fill_go ? fill_word : pop_word[DATA_W-1:0];
                    cd_d   = fill_go ? 1'b1 : pop_word[DATA_W];
                end
            end
            S_SETUP: begin
                if (setup_done) begin
                    cnt_d = '0;
                    we_d  = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    cnt_d = '0;
                    we_d  = 1'b0;
                end
            end
            default: begin
                cnt_d = '0;
                we_d  = 1'b0;
            end
        endcase
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign nreset      = nreset_q;
    assign cmd_data    = cd_q;
    assign write_edge  = we_q;
    assign dout        = dout_q;

endmodule

// File: tb/tb_lcd_bus_fifo.sv
// Self-checking bench for lcd_bus_fifo. Expected LCD words are queued when
// DATA/FILL writes are issued and compared on every rising write_edge.
// Long strobe timing is used so back-to-back CPU writes can fill the FIFO.
// Fill tests run when the bench is compiled with `define LCD_FILL_EN.
module tb_lcd_bus_fifo;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int WR_LOW_CYC  = 40;
    localparam int WR_HIGH_CYC = 20;

    localparam logic [7:0] A_DATA       = 8'h00;
    localparam logic [7:0] A_STATUS     = 8'h04;
    localparam logic [7:0] A_DC         = 8'h08;
    localparam logic [7:0] A_NRESET     = 8'h0C;
    localparam logic [7:0] A_FILL_COLOR = 8'h10;
    localparam logic [7:0] A_FILL_COUNT = 8'h14;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              iomem_valid = 1'b0;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb = 4'h0;
    logic [31:0]       iomem_addr = 32'h0;
    logic [31:0]       iomem_wdata = 32'h0;
    logic [31:0]       iomem_rdata;
    logic              nreset;
    logic              cmd_data;
    logic              write_edge;
    logic [DATA_W-1:0] dout;

    lcd_bus_fifo #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .WR_LOW_CYC  (WR_LOW_CYC),
        .WR_HIGH_CYC (WR_HIGH_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .nreset      (nreset),
        .cmd_data    (cmd_data),
        .write_edge  (write_edge),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard of {cmd_data, dout} words expected on the LCD bus.
    logic [DATA_W:0] exp_q[$];
    logic            dc_model = 1'b0;
    int              strobes = 0;

    // LCD-side monitor: compares each rising write_edge, checks the word is
    // stable while high, checks the high width, and checks ready is a pulse.
    logic            we_prev = 1'b0;
    logic            rdy_prev = 1'b0;
    logic [DATA_W:0] held = '0;
    int              high_cnt = 0;

    always @(negedge clk) begin
        if (reset) begin
            we_prev  = 1'b0;
            rdy_prev = 1'b0;
            high_cnt = 0;
        end else begin
            if (rdy_prev && iomem_ready) check("ready_pulse", 32'(iomem_ready), 32'h0);
            rdy_prev = iomem_ready;
            if (write_edge && !we_prev) begin
                strobes++;
                held     = {cmd_data, dout};
                high_cnt = 1;
                if (exp_q.size() == 0) check("strobe_unexpected", 32'(held), 32'hFFFF_FFFF);
                else                   check("strobe_word", 32'(held), 32'(exp_q.pop_front()));
            end else if (write_edge && we_prev) begin
                high_cnt++;
                check("strobe_stable", 32'({cmd_data, dout}), 32'(held));
            end else if (!write_edge && we_prev) begin
                check("high_width", 32'(high_cnt), 32'(WR_HIGH_CYC));
            end
            we_prev = write_edge;
        end
    end

    // One iomem transaction; lat counts cycles from acceptance edge to ready.
    task automatic bus_xfer(input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata,
                            output int lat);
        @(posedge clk); #1;
        iomem_valid = 1'b1;
        iomem_addr  = {24'h0, addr};
        iomem_wdata = wdata;
        iomem_wstrb = wstrb;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!iomem_ready && lat < 4000);
        if (!iomem_ready) check("bus_timeout", 32'(iomem_ready), 32'h1);
        rdata       = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] wdata, output int lat);
        logic [31:0] rd;
        bus_xfer(addr, wdata, 4'hF, rd, lat);
        if (addr == A_DC) dc_model = wdata[0];
    endtask

    task automatic push_byte(input logic [7:0] b, output int lat);
        exp_q.push_back({dc_model, b});
        wr(A_DATA, {24'h0, b}, lat);
    endtask

    task automatic rd_reg(input logic [7:0] addr, output logic [31:0] val);
        int lat;
        bus_xfer(addr, 32'h0, 4'h0, val, lat);
    endtask

    task automatic wait_idle(input string tag, output logic [31:0] s);
        int polls = 0;
        do begin
            rd_reg(A_STATUS, s);
            polls++;
        end while (s[0] && polls < 3000);
        check({tag, "_idle"}, 32'(s[0]), 32'h0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int          lat;
        int          k;
        int          s0;
        logic [31:0] s;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_nreset", 32'(nreset), 32'h1);
        check("rst_cmd_data", 32'(cmd_data), 32'h0);
        check("rst_write_edge", 32'(write_edge), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_ready", 32'(iomem_ready), 32'h0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        rd_reg(A_STATUS, s);
        check("rst_status", s, 32'h0);

        // Command then data, each write acknowledged one cycle later.
        wr(A_DC, 32'h0, lat);          check("t1_dc0_lat", 32'(lat), 32'h1);
        push_byte(8'h2A, lat);         check("t1_push0_lat", 32'(lat), 32'h1);
        wr(A_DC, 32'h1, lat);          check("t1_dc1_lat", 32'(lat), 32'h1);
        push_byte(8'h00, lat);         check("t1_push1_lat", 32'(lat), 32'h1);
        rd_reg(A_DC, s);               check("t1_dc_reads_zero", s, 32'h0);
        wr(8'h20, 32'hFFFF_FFFF, lat); check("t1_unmapped_lat", 32'(lat), 32'h1);
        wait_idle("t1", s);

        // Fill the FIFO back-to-back: one entry leaves immediately, the
        // next pop is a full strobe period later, so 17 pushes fill it.
        for (int i = 0; i < 17; i++) push_byte(8'(8'h40 + i), lat);
        rd_reg(A_STATUS, s);
        check("t2_full", 32'(s[1]), 32'h1);
        check("t2_level", 32'(s[15:8]), 32'(FIFO_DEPTH));
        push_byte(8'h51, lat);         check("t2_withheld", 32'(lat > 1), 32'h1);
        for (int i = 0; i < 2; i++) push_byte(8'(8'h52 + i), lat);
        wait_idle("t2", s);
        check("t2_count", 32'(strobes), 32'd22);

        // NRESET is immediate; DC is captured per entry.
        wr(A_DC, 32'h1, lat);
        push_byte(8'hA1, lat);
        push_byte(8'hA2, lat);
        wr(A_DC, 32'h0, lat);
        push_byte(8'hA3, lat);
        push_byte(8'hA4, lat);
        wr(A_NRESET, 32'h0, lat);
        check("t3_nreset_low", 32'(nreset), 32'h0);
        rd_reg(A_STATUS, s);           check("t3_busy", 32'(s[0]), 32'h1);
        wait_idle("t3", s);
        check("t3_status_clear", s, 32'h0);
        wr(A_NRESET, 32'h1, lat);
        check("t3_nreset_high", 32'(nreset), 32'h1);

        // Reset during HOLD with entries still queued.
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i), lat);
        k = 0;
        while (!write_edge && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t4_reach_hold", 32'(write_edge), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("t4_we_drop", 32'(write_edge), 32'h0);
        check("t4_dout_clr", 32'(dout), 32'h0);
        exp_q.delete();
        dc_model = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        rd_reg(A_STATUS, s);           check("t4_status", s, 32'h0);
        s0 = strobes;
        repeat (300) @(posedge clk);
        check("t4_no_strobes", 32'(strobes), 32'(s0));
        push_byte(8'h55, lat);         // DC register was cleared by reset
        wait_idle("t4", s);

`ifdef LCD_FILL_EN
        // Fill of three RGB565 pixels, high byte first.
        wr(A_FILL_COLOR, 32'h0000_F800, lat);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b1, 8'hF8});
            exp_q.push_back({1'b1, 8'h00});
        end
        wr(A_FILL_COUNT, 32'd3, lat);
        rd_reg(A_STATUS, s);           check("t5_fill_flag", 32'(s[2]), 32'h1);
        wait_idle("t5", s);
        check("t5_fill_clear", 32'(s[2]), 32'h0);
        wr(A_FILL_COUNT, 32'd0, lat);
        rd_reg(A_STATUS, s);           check("t5_zero_noop", s, 32'h0);

        // Ordering: queued data, fill, later data, then a second fill that
        // is withheld until the first one finishes.
        wr(A_DC, 32'h0, lat);
        push_byte(8'h2C, lat);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b1, 8'hF8});
            exp_q.push_back({1'b1, 8'h00});
        end
        wr(A_FILL_COUNT, 32'd2, lat);
        push_byte(8'h00, lat);
        exp_q.push_back({1'b1, 8'hF8});
        exp_q.push_back({1'b1, 8'h00});
        wr(A_FILL_COUNT, 32'd1, lat);  check("t6_count_withheld", 32'(lat > 1), 32'h1);
        wait_idle("t6", s);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
